// File: rtl/cout_merge_pkg.sv
// Shared sizing, mode/state encodings and width helper for the cout_merge block.
package cout_merge_pkg;
`include "Para.v"

  localparam int DATA_W         = `WIDTH_DATA;
  localparam int PIC_NUM        = `PICTURE_NUM;
  localparam int CH_OUT_DEFAULT = `Channel_Out_Num;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_MERGE  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } merge_state_e;

  // Width of one half beat: half of the output channels, all pictures, all data bits.
  function automatic int half_width(input int ch_out);
    return DATA_W * PIC_NUM * (ch_out / 2);
  endfunction

endpackage

// File: rtl/Para.v
// Shared datapath sizing used by the feature-map pipeline blocks.
`ifndef PARA_V
`define PARA_V
`define WIDTH_DATA      8
`define PICTURE_NUM     1
`define Channel_Out_Num 16
`endif

// File: rtl/cout_merge_core.sv
// Merge engine: pairs two half-width beats into one full word with a
// single-entry output slot and valid/ready handshakes on both sides.
module cout_merge_core
  import cout_merge_pkg::*;
#(
  parameter int HW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HW-1:0]   S_Feature,
  input  logic            S_Valid,
  output logic            S_Ready,
  output logic [2*HW-1:0] M_Feature,
  output logic            M_Valid,
  input  logic            M_Ready
);

  logic [HW-1:0]   r_lo_data;
  logic            r_lo_valid;
  logic [2*HW-1:0] r_out_data;
  logic            r_out_valid;

  merge_state_e w_state;
  logic         w_accept;

  assign w_state  = r_lo_valid ? ST_HALF : ST_EMPTY;
  // A completing beat needs the output slot free or draining this cycle.
  assign S_Ready  = !r_lo_valid || !r_out_valid || M_Ready;
  assign w_accept = S_Valid && S_Ready;

  assign M_Valid   = r_out_valid;
  assign M_Feature = r_out_data;

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value; the data registers are reset too, so the
  // word presented after reset is a defined zero rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo_data   <= '0;
      r_lo_valid  <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && M_Ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        case (w_state)
          ST_EMPTY: begin
            r_lo_data  <= S_Feature;
            r_lo_valid <= 1'b1;
          end
          ST_HALF: begin
            r_out_data  <= {S_Feature, r_lo_data};
            r_out_valid <= 1'b1;
            r_lo_valid  <= 1'b0;
          end
          default: r_lo_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/cout_merge.sv
// Output-channel merge wrapper: combinational bypass, or pairs half-width
// beats into full words through cout_merge_core.
module cout_merge
  import cout_merge_pkg::*;
#(
  parameter  int CHANNEL_OUT_NUM = CH_OUT_DEFAULT,
  localparam int HALF_NUM        = CHANNEL_OUT_NUM / 2,
  localparam int HW              = half_width(CHANNEL_OUT_NUM),
  localparam int FW              = 2 * HW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EN_Merge_REG,
  input  logic [FW-1:0] S_Feature,
  input  logic          S_Valid,
  output logic          S_Ready,
  output logic [FW-1:0] M_Feature,
  output logic          M_Valid,
  input  logic          M_Ready
);

  mode_e         w_mode;
  logic          w_core_rst;
  logic          w_core_s_valid;
  logic          w_core_s_ready;
  logic [FW-1:0] w_core_m_feature;
  logic          w_core_m_valid;

  assign w_mode = mode_e'(EN_Merge_REG);

  // Holding the core in reset throughout bypass discards any partial or
  // pending word on the edge after a mode change and keeps both flags at zero.
  assign w_core_rst     = rst || (w_mode == MODE_BYPASS);
  assign w_core_s_valid = S_Valid && (w_mode == MODE_MERGE);

  cout_merge_core #(
    .HW (HW)
  ) u_core (
    .clk       (clk),
    .rst       (w_core_rst),
    .S_Feature (S_Feature[HW-1:0]),
    .S_Valid   (w_core_s_valid),
    .S_Ready   (w_core_s_ready),
    .M_Feature (w_core_m_feature),
    .M_Valid   (w_core_m_valid),
    .M_Ready   (M_Ready)
  );

  // NOTE: every output gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    S_Ready   = M_Ready;
    M_Valid   = S_Valid;
    M_Feature = S_Feature;
    if (w_mode == MODE_MERGE) begin
      S_Ready   = w_core_s_ready;
      M_Valid   = w_core_m_valid && !rst;
      M_Feature = rst ? '0 : w_core_m_feature;
    end
  end

endmodule

// File: tb/tb_cout_merge.sv
// Self-checking bench for cout_merge: directed scenarios plus random traffic,
// checked by a beat-pairing reference model and an expected-word queue.
module tb_cout_merge;
  import cout_merge_pkg::*;

  localparam int HW = 64;
  localparam int FW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [FW-1:0] s_feat;
  logic          s_valid;
  logic          s_ready;
  logic [FW-1:0] m_feat;
  logic          m_valid;
  logic          m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [HW-1:0] half_q[$];
  logic [FW-1:0] word_q[$];

  cout_merge #(
    .CHANNEL_OUT_NUM (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .EN_Merge_REG (en),
    .S_Feature    (s_feat),
    .S_Valid      (s_valid),
    .S_Ready      (s_ready),
    .M_Feature    (m_feat),
    .M_Valid      (m_valid),
    .M_Ready      (m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic e, input logic v,
                     input logic [FW-1:0] d, input logic mr);
    @(posedge clk);
    #1;
    rst     = r;
    en      = e;
    s_valid = v;
    s_feat  = d;
    m_ready = mr;
    @(negedge clk);
  endtask

  function automatic logic [FW-1:0] beat(input logic [HW-1:0] lo);
    return {$urandom, $urandom, lo};
  endfunction

  // Monitor and reference model: compare outputs against the expected-word
  // queue, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    logic exp_rdy;
    if (!en) begin
      check("byp_feature", m_feat, s_feat);
      check("byp_valid", m_valid, s_valid);
      check("byp_ready", s_ready, m_ready);
      half_q.delete();
      word_q.delete();
    end else begin
      exp_rdy = (half_q.size() == 0) || (word_q.size() == 0) || m_ready;
      check("s_ready", s_ready, exp_rdy);
      if (rst) begin
        check("rst_valid", m_valid, 1'b0);
        check("rst_feature", m_feat, '0);
        half_q.delete();
        word_q.delete();
      end else begin
        if (word_q.size() != 0) begin
          check("m_valid", m_valid, 1'b1);
          check("m_feature", m_feat, word_q[0]);
          if (m_ready) void'(word_q.pop_front());
        end else begin
          check("m_idle", m_valid, 1'b0);
        end
        if (s_valid && exp_rdy) begin
          half_q.push_back(s_feat[HW-1:0]);
          if (half_q.size() == 2) begin
            word_q.push_back({half_q[1], half_q[0]});
            half_q.delete();
          end
        end
      end
    end
  end

  initial begin
    logic [FW-1:0] a5;
    logic [HW-1:0] h1, h2, pa, pb, pc, pd;
    rst = 1'b1; en = 1'b1; s_valid = 1'b0; s_feat = '0; m_ready = 1'b0;

    cyc(1, 1, 0, '0, 0);
    cyc(1, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    check("reset_valid", m_valid, 1'b0);
    check("reset_feature", m_feat, '0);
    check("reset_ready", s_ready, 1'b1);

    // Bypass is combinational and passes the full word and handshake.
    a5 = {16{8'hA5}};
    cyc(0, 0, 1, a5, 0);
    check("bypass_feature", m_feat, a5);
    check("bypass_valid", m_valid, 1'b1);
    check("bypass_ready", s_ready, 1'b0);

    // Basic merge: first beat forms the low half.
    h1 = 64'h1111_1111_1111_1111;
    h2 = 64'h2222_2222_2222_2222;
    cyc(0, 1, 1, beat(h1), 1);
    cyc(0, 1, 1, beat(h2), 1);
    cyc(0, 1, 0, '0, 1);
    check("basic_valid", m_valid, 1'b1);
    check("basic_word", m_feat, {h2, h1});
    cyc(0, 1, 0, '0, 1);
    check("basic_one_cycle", m_valid, 1'b0);

    // Streaming eight beats with no backpressure.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, beat(64'(i)), 1);
      check("stream_ready", s_ready, 1'b1);
      if (i >= 2 && i % 2 == 0) check("stream_word", m_feat, {64'(i - 1), 64'(i - 2)});
      check("stream_valid", m_valid, (i >= 2 && i % 2 == 0) ? 1'b1 : 1'b0);
    end
    cyc(0, 1, 0, '0, 1);
    check("stream_last", m_feat, {64'd7, 64'd6});

    // Backpressure with a pending word.
    pa = 64'hAAAA_0000_0000_0001; pb = 64'hBBBB_0000_0000_0002;
    pc = 64'hCCCC_0000_0000_0003; pd = 64'hDDDD_0000_0000_0004;
    cyc(0, 1, 1, beat(pa), 1);
    cyc(0, 1, 1, beat(pb), 0);
    cyc(0, 1, 1, beat(pc), 0);
    check("bp_first_accept", s_ready, 1'b1);
    cyc(0, 1, 1, beat(pd), 0);
    check("bp_second_refused", s_ready, 1'b0);
    check("bp_stable", m_feat, {pb, pa});
    cyc(0, 1, 1, beat(pd), 0);
    check("bp_stable2", m_feat, {pb, pa});
    cyc(0, 1, 1, beat(pd), 1);
    check("bp_drain_accept", s_ready, 1'b1);
    cyc(0, 1, 0, '0, 1);
    check("bp_new_word", m_feat, {pd, pc});

    // Mode change mid-merge discards the partial beat.
    cyc(0, 1, 1, beat(64'hDEAD_BEEF_DEAD_BEEF), 1);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 1, 0, '0, 1);
    cyc(0, 1, 1, beat(pa), 1);
    cyc(0, 1, 1, beat(pb), 1);
    cyc(0, 1, 0, '0, 1);
    check("mode_fresh_word", m_feat, {pb, pa});

    // Reset with both a pending word and a half beat held.
    cyc(0, 1, 1, beat(pa), 0);
    cyc(0, 1, 1, beat(pb), 0);
    cyc(0, 1, 1, beat(pc), 0);
    cyc(1, 1, 1, beat(pd), 0);
    cyc(0, 1, 0, '0, 0);
    check("rst_mid_valid", m_valid, 1'b0);
    check("rst_mid_feature", m_feat, '0);
    check("rst_mid_ready", s_ready, 1'b1);

    // Random traffic with occasional mode toggles and resets.
    for (int k = 0; k < 1500; k++) begin
      logic e_n;
      e_n = en;
      if ($urandom_range(0, 99) < 3) e_n = ~en;
      cyc(($urandom_range(0, 99) == 0), e_n, ($urandom_range(0, 3) != 0),
          {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end

    cyc(0, 1, 0, '0, 1);
    cyc(0, 1, 0, '0, 1);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cout_merge.md
COUT_MERGE -- requirements
Module: cout_merge

Interface
REQ-001 The module SHALL have parameter CHANNEL_OUT_NUM, default 16, giving the number of output channels per full word; it SHALL be even.
REQ-002 The module SHALL derive HALF_NUM = CHANNEL_OUT_NUM/2, HW = `WIDTH_DATA*`PICTURE_NUM*HALF_NUM and FW = 2*HW.
REQ-003 The module SHALL have the following ports:
  clk  input  1  single clock; all logic rising-edge.
  rst  input  1  synchronous, active-high reset.
  EN_Merge_REG  input  1  1 = merge two half-width beats into one word; 0 = bypass.
  S_Feature  input  FW  input data; only bits [HW-1:0] are used in merge mode.
  S_Valid  input  1  input beat valid.
  S_Ready  output  1  input beat accepted when S_Valid && S_Ready.
  M_Feature  output  FW  output data.
  M_Valid  output  1  output word valid.
  M_Ready  input  1  downstream accepts when M_Valid && M_Ready.

Function
REQ-004 Bypass (EN_Merge_REG=0): M_Feature=S_Feature, M_Valid=S_Valid and S_Ready=M_Ready, all combinational with zero latency.
REQ-005 Merge mode SHALL keep a low-half register lo_data (HW), a flag lo_valid, an output register out_data (FW) and a flag out_valid.
REQ-006 Merge-mode state: EMPTY (!lo_valid); HALF (lo_valid).
  out_valid is an independent output slot.
REQ-007 Merge mode: S_Ready = !lo_valid || !out_valid || M_Ready.
REQ-008 Beat accepted in EMPTY: lo_data <= S_Feature[HW-1:0]; lo_valid <= 1.
REQ-009 Beat accepted in HALF: out_data <= {S_Feature[HW-1:0], lo_data}, so the first beat forms the low half; then out_valid <= 1 and lo_valid <= 0.
REQ-010 Merge mode: M_Valid=out_valid and M_Feature=out_data.
  Latency: the word is visible the cycle after the second beat is accepted.
REQ-011 When M_Valid && M_Ready with no new completing beat, out_valid SHALL clear next cycle.
  With a completing beat in the same cycle, out_valid SHALL stay 1 and out_data SHALL take the new word.
REQ-012 Sustained throughput SHALL be one input beat per cycle and one output word per two cycles, with no bubble when M_Ready is held at 1.
REQ-013 While out_valid && !M_Ready, a first-half beat SHALL still be accepted in EMPTY.
  A second-half beat SHALL be refused in HALF (S_Ready=0).
REQ-014 While M_Valid && !M_Ready, M_Feature SHALL remain stable.
REQ-015 On the cycle after EN_Merge_REG changes value, lo_valid and out_valid SHALL be cleared and any partial or pending merge data discarded.
REQ-016 While EN_Merge_REG=0, lo_valid and out_valid SHALL be held at 0.
REQ-017 Odd beat counts are not padded: a trailing single half beat SHALL remain in HALF until a further beat, a mode change, or reset.

Reset
REQ-018 On rst=1 at a clock edge: lo_valid=0, out_valid=0, lo_data=0, out_data=0.
REQ-019 During reset in merge mode: M_Valid=0 and M_Feature=0.
  In bypass, outputs follow REQ-004 regardless of rst.
REQ-020 Reset SHALL take priority over acceptance and mode-change clearing in the same cycle.
  After deassertion the block is in EMPTY.

Structure
REQ-021 `WIDTH_DATA, `PICTURE_NUM and `Channel_Out_Num SHALL come from the shared Para.v include; no local redefinition.
REQ-022 Merge registers and handshake logic SHALL live in one sub-module, cout_merge_core (ports clk, rst, S_Feature[HW], S_Valid, S_Ready, M_Feature[FW], M_Valid, M_Ready).
  cout_merge SHALL hold only the bypass muxing and mode-change clear.
REQ-023 All sequential logic SHALL be in cout_merge_core, single clock domain.

Verification
Bench parameters: WIDTH_DATA=8, PICTURE_NUM=1, CHANNEL_OUT_NUM=16 (HW=64, FW=128).
REQ-024 Bypass: EN=0, S_Feature=128'hA5..A5, S_Valid=1, M_Ready=0.
  Required: same-cycle M_Feature=128'hA5..A5, M_Valid=1, S_Ready=0.
REQ-025 Basic merge: EN=1, M_Ready=1, beats 64'h1111_1111_1111_1111 then 64'h2222_2222_2222_2222 on consecutive cycles.
  Required: next cycle M_Valid=1 and M_Feature={64'h2222..., 64'h1111...}, for one cycle.
REQ-026 Streaming: 8 consecutive beats 0..7 with M_Ready=1.
  Required: S_Ready constantly 1.
  Required: words {1,0},{3,2},{5,4},{7,6} on alternate cycles.
REQ-027 Backpressure: word pending, M_Ready=0, two more beats offered.
  Required: first beat accepted, second refused, M_Feature stable.
  Then M_Ready=1: pending word drains, second beat is accepted the same cycle, and the new word follows next cycle.
REQ-028 Mode change mid-merge: one beat accepted (HALF), then EN toggled 1->0->1.
  Required: the partial beat is discarded, and the next two beats form a fresh word.
REQ-029 Reset mid-operation: rst=1 with out_valid=1 and lo_valid=1.
  Required: next cycle M_Valid=0, M_Feature=0, S_Ready=1.
